// File: rtl/cpu_run_ctrl.sv
// Run controller in front of the CPU clock phaser: stop, resume and single-step
// the 65C02 at a safe phase, plus a free-running CPU cycle counter.
module cpu_run_ctrl #(
    parameter bit RUN_AT_RESET = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk6x,
    input  logic             resetn,
    input  logic             stopped,
    input  logic             setup_cs,
    input  logic             cpu_sync,
    input  logic             cmd_stop,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             step_instr,
    input  logic [15:0]      step_count,
    input  logic             cmd_clr_cnt,
    output logic             run,
    output logic             halted,
    output logic             busy,
    output logic [15:0]      steps_left,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_RUNNING  = 2'd0,
        S_STOPPING = 2'd1,
        S_HALTED   = 2'd2,
        S_STEPPING = 2'd3
    } state_t;

    localparam state_t RESET_STATE = RUN_AT_RESET ? S_RUNNING : S_STOPPING;

    state_t           state_q, state_d;
    logic             run_q, run_d;
    logic             halted_q, halted_d;
    logic             busy_q, busy_d;
    logic [15:0]      steps_left_q, steps_left_d;
    logic             step_instr_q, step_instr_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             unit_evt;

    // A step unit is one started CPU cycle, or only opcode-fetch cycles in instruction mode.
    assign unit_evt = setup_cs && (!step_instr_q || cpu_sync);

    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        step_instr_d = step_instr_q;

        case (state_q)
            S_RUNNING: begin
                if (cmd_stop) begin
                    state_d = S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (!cmd_stop && cmd_run) begin
                    state_d = S_RUNNING;
                end else if (stopped) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                if (cmd_stop) begin
                    state_d = S_HALTED;
                end else if (cmd_run) begin
                    state_d = S_RUNNING;
                end else if (cmd_step && (step_count != 16'd0)) begin
                    state_d      = S_STEPPING;
                    steps_left_d = step_count;
                    step_instr_d = step_instr;
                end
            end
            S_STEPPING: begin
                if (cmd_stop) begin
                    state_d = S_STOPPING;
                end else if (cmd_run) begin
                    state_d      = S_RUNNING;
                    steps_left_d = 16'd0;
                end else if (unit_evt) begin
                    steps_left_d = steps_left_q - 16'd1;
                    // run drops on the edge after the last counted setup_cs, well before the hold phase.
                    if (steps_left_q == 16'd1) begin
                        state_d = S_STOPPING;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_comb begin
        run_d    = (state_d == S_RUNNING) || (state_d == S_STEPPING);
        halted_d = (state_d == S_HALTED);
        busy_d   = (state_d == S_STOPPING) || (state_d == S_STEPPING);
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (cmd_clr_cnt) begin
            cycle_cnt_d = '0;
        end else if (setup_cs) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RESET_STATE;
            run_q        <= RUN_AT_RESET;
            halted_q     <= 1'b0;
            busy_q       <= !RUN_AT_RESET;
            steps_left_q <= 16'd0;
            step_instr_q <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            halted_q     <= halted_d;
            busy_q       <= busy_d;
            steps_left_q <= steps_left_d;
            step_instr_q <= step_instr_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign run        = run_q;
    assign halted     = halted_q;
    assign busy       = busy_q;
    assign steps_left = steps_left_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a boot-running 32-bit instance and a
// boot-held 4-bit instance used for the counter wrap and held-boot checks.
module tb_cpu_run_ctrl;

    logic        clk6x = 1'b0;
    logic        resetn = 1'b1;
    logic        stopped = 1'b0, setup_cs = 1'b0, cpu_sync = 1'b0;
    logic        cmd_stop = 1'b0, cmd_run = 1'b0, cmd_step = 1'b0;
    logic        step_instr = 1'b0, cmd_clr_cnt = 1'b0;
    logic [15:0] step_count = 16'd0;
    logic        run, halted, busy;
    logic [15:0] steps_left;
    logic [31:0] cycle_cnt;

    logic        stopped1 = 1'b0, setup_cs1 = 1'b0, cpu_sync1 = 1'b0;
    logic        cmd_stop1 = 1'b0, cmd_run1 = 1'b0, cmd_step1 = 1'b0;
    logic        step_instr1 = 1'b0, cmd_clr_cnt1 = 1'b0;
    logic [15:0] step_count1 = 16'd0;
    logic        run1, halted1, busy1;
    logic [15:0] steps_left1;
    logic [3:0]  cycle_cnt1;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk6x = ~clk6x;

    cpu_run_ctrl #(.RUN_AT_RESET(1'b1), .CNT_W(32)) dut (
        .clk6x(clk6x), .resetn(resetn), .stopped(stopped), .setup_cs(setup_cs),
        .cpu_sync(cpu_sync), .cmd_stop(cmd_stop), .cmd_run(cmd_run), .cmd_step(cmd_step),
        .step_instr(step_instr), .step_count(step_count), .cmd_clr_cnt(cmd_clr_cnt),
        .run(run), .halted(halted), .busy(busy), .steps_left(steps_left),
        .cycle_cnt(cycle_cnt)
    );

    cpu_run_ctrl #(.RUN_AT_RESET(1'b0), .CNT_W(4)) dut_held (
        .clk6x(clk6x), .resetn(resetn), .stopped(stopped1), .setup_cs(setup_cs1),
        .cpu_sync(cpu_sync1), .cmd_stop(cmd_stop1), .cmd_run(cmd_run1), .cmd_step(cmd_step1),
        .step_instr(step_instr1), .step_count(step_count1), .cmd_clr_cnt(cmd_clr_cnt1),
        .run(run1), .halted(halted1), .busy(busy1), .steps_left(steps_left1),
        .cycle_cnt(cycle_cnt1)
    );

    task automatic tick();
        @(posedge clk6x);
        #1;
    endtask

    // One CPU cycle start followed by an idle clock.
    task automatic cs_pulse(input logic sync);
        setup_cs = 1'b1;
        cpu_sync = sync;
        tick();
        setup_cs = 1'b0;
        cpu_sync = 1'b0;
        tick();
    endtask

    task automatic go_halted();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        stopped = 1'b1;
        tick();
        ncmp++;
        if ({run, halted, busy} !== 3'b010) begin
            nfail++;
            $display("FAIL go_halted rhb got=%b exp=010", {run, halted, busy});
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        ncmp++;
        if ({run, halted, busy, steps_left, cycle_cnt} !== {3'b100, 16'd0, 32'd0}) begin
            nfail++;
            $display("FAIL reset_run rhb=%b steps=%0d cnt=%0d exp rhb=100 0 0",
                     {run, halted, busy}, steps_left, cycle_cnt);
        end
        ncmp++;
        if ({run1, halted1, busy1, steps_left1, cycle_cnt1} !== {3'b001, 16'd0, 4'd0}) begin
            nfail++;
            $display("FAIL reset_held rhb=%b steps=%0d cnt=%0d exp rhb=001 0 0",
                     {run1, halted1, busy1}, steps_left1, cycle_cnt1);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 20; i++) cs_pulse(1'b0);
        ncmp++;
        if ({run, halted, busy, cycle_cnt} !== {3'b100, 32'd20}) begin
            nfail++;
            $display("FAIL free_run rhb=%b cnt=%0d exp rhb=100 cnt=20", {run, halted, busy}, cycle_cnt);
        end
    endtask

    task automatic test_stop();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        ncmp++;
        if ({run, halted, busy} !== 3'b001) begin
            nfail++;
            $display("FAIL stop_latency rhb got=%b exp=001", {run, halted, busy});
        end
        tick();
        tick();
        stopped = 1'b1;
        tick();
        ncmp++;
        if ({run, halted, busy} !== 3'b010) begin
            nfail++;
            $display("FAIL stop_halted rhb got=%b exp=010", {run, halted, busy});
        end
        for (int i = 0; i < 10; i++) tick();
        ncmp++;
        if (cycle_cnt !== 32'd20) begin
            nfail++;
            $display("FAIL stop_cnt_frozen got=%0d exp=20", cycle_cnt);
        end
    endtask

    task automatic test_step_cycles();
        logic [15:0] exp_steps [3] = '{16'd2, 16'd1, 16'd0};
        logic [2:0]  exp_rhb   [3] = '{3'b101, 3'b101, 3'b001};
        cmd_step = 1'b1;
        step_count = 16'd3;
        step_instr = 1'b0;
        tick();
        cmd_step = 1'b0;
        stopped = 1'b0;
        ncmp++;
        if ({run, halted, busy, steps_left} !== {3'b101, 16'd3}) begin
            nfail++;
            $display("FAIL step_cyc_load rhb=%b steps=%0d exp rhb=101 steps=3", {run, halted, busy}, steps_left);
        end
        for (int i = 0; i < 3; i++) begin
            setup_cs = 1'b1;
            tick();
            setup_cs = 1'b0;
            ncmp++;
            if ({run, halted, busy, steps_left} !== {exp_rhb[i], exp_steps[i]}) begin
                nfail++;
                $display("FAIL step_cyc_evt%0d rhb=%b steps=%0d exp rhb=%b steps=%0d",
                         i, {run, halted, busy}, steps_left, exp_rhb[i], exp_steps[i]);
            end
            tick();
        end
        stopped = 1'b1;
        tick();
        ncmp++;
        if ({run, halted, busy, cycle_cnt} !== {3'b010, 32'd23}) begin
            nfail++;
            $display("FAIL step_cyc_done rhb=%b cnt=%0d exp rhb=010 cnt=23", {run, halted, busy}, cycle_cnt);
        end
    endtask

    task automatic test_step_instr();
        logic        sync_pat  [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] exp_steps [3] = '{16'd1, 16'd1, 16'd0};
        logic        exp_run   [3] = '{1'b1, 1'b1, 1'b0};
        cmd_step = 1'b1;
        step_count = 16'd2;
        step_instr = 1'b1;
        tick();
        cmd_step = 1'b0;
        step_instr = 1'b0;
        stopped = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setup_cs = 1'b1;
            cpu_sync = sync_pat[i];
            tick();
            setup_cs = 1'b0;
            cpu_sync = 1'b0;
            ncmp++;
            if ({run, steps_left} !== {exp_run[i], exp_steps[i]}) begin
                nfail++;
                $display("FAIL step_ins_cyc%0d run=%b steps=%0d exp run=%b steps=%0d",
                         i + 1, run, steps_left, exp_run[i], exp_steps[i]);
            end
            tick();
        end
        stopped = 1'b1;
        tick();
        ncmp++;
        if ({run, halted, busy, cycle_cnt} !== {3'b010, 32'd26}) begin
            nfail++;
            $display("FAIL step_ins_done rhb=%b cnt=%0d exp rhb=010 cnt=26", {run, halted, busy}, cycle_cnt);
        end
        cmd_step = 1'b1;
        step_count = 16'd0;
        tick();
        cmd_step = 1'b0;
        ncmp++;
        if ({run, halted, busy, steps_left} !== {3'b010, 16'd0}) begin
            nfail++;
            $display("FAIL step_zero rhb=%b steps=%0d exp rhb=010 steps=0", {run, halted, busy}, steps_left);
        end
    endtask

    task automatic test_priority();
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        stopped = 1'b0;
        ncmp++;
        if ({run, halted, busy} !== 3'b100) begin
            nfail++;
            $display("FAIL resume rhb got=%b exp=100", {run, halted, busy});
        end
        cmd_step = 1'b1;
        step_count = 16'd4;
        tick();
        cmd_step = 1'b0;
        ncmp++;
        if ({run, halted, busy, steps_left} !== {3'b100, 16'd0}) begin
            nfail++;
            $display("FAIL step_in_running rhb=%b steps=%0d exp rhb=100 steps=0", {run, halted, busy}, steps_left);
        end
        cmd_stop = 1'b1;
        cmd_run = 1'b1;
        tick();
        cmd_stop = 1'b0;
        cmd_run = 1'b0;
        ncmp++;
        if ({run, halted, busy} !== 3'b001) begin
            nfail++;
            $display("FAIL stop_plus_run rhb got=%b exp=001", {run, halted, busy});
        end
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        ncmp++;
        if ({run, halted, busy} !== 3'b100) begin
            nfail++;
            $display("FAIL run_from_stopping rhb got=%b exp=100", {run, halted, busy});
        end
    endtask

    task automatic test_clr_cnt();
        setup_cs = 1'b1;
        cmd_clr_cnt = 1'b1;
        tick();
        setup_cs = 1'b0;
        cmd_clr_cnt = 1'b0;
        ncmp++;
        if (cycle_cnt !== 32'd0) begin
            nfail++;
            $display("FAIL clr_beats_cs got=%0d exp=0", cycle_cnt);
        end
        cs_pulse(1'b0);
        ncmp++;
        if (cycle_cnt !== 32'd1) begin
            nfail++;
            $display("FAIL cnt_after_clr got=%0d exp=1", cycle_cnt);
        end
    endtask

    task automatic test_wrap_and_held_boot();
        for (int i = 0; i < 15; i++) begin
            setup_cs1 = 1'b1;
            tick();
            setup_cs1 = 1'b0;
            tick();
        end
        ncmp++;
        if (cycle_cnt1 !== 4'hF) begin
            nfail++;
            $display("FAIL wrap_max got=%0d exp=15", cycle_cnt1);
        end
        setup_cs1 = 1'b1;
        tick();
        setup_cs1 = 1'b0;
        ncmp++;
        if (cycle_cnt1 !== 4'h0) begin
            nfail++;
            $display("FAIL wrap_zero got=%0d exp=0", cycle_cnt1);
        end
        stopped1 = 1'b1;
        tick();
        ncmp++;
        if ({run1, halted1, busy1} !== 3'b010) begin
            nfail++;
            $display("FAIL held_boot_halt rhb got=%b exp=010", {run1, halted1, busy1});
        end
    endtask

    task automatic test_step_abort();
        go_halted();
        cmd_step = 1'b1;
        step_count = 16'd10;
        tick();
        cmd_step = 1'b0;
        stopped = 1'b0;
        for (int i = 0; i < 5; i++) cs_pulse(1'b0);
        cmd_stop = 1'b1;
        setup_cs = 1'b1;
        tick();
        cmd_stop = 1'b0;
        setup_cs = 1'b0;
        ncmp++;
        if ({run, halted, busy, steps_left} !== {3'b001, 16'd5}) begin
            nfail++;
            $display("FAIL abort_stop rhb=%b steps=%0d exp rhb=001 steps=5", {run, halted, busy}, steps_left);
        end
        stopped = 1'b1;
        tick();
        cmd_step = 1'b1;
        step_count = 16'd10;
        tick();
        cmd_step = 1'b0;
        stopped = 1'b0;
        cs_pulse(1'b0);
        cs_pulse(1'b0);
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        ncmp++;
        if ({run, halted, busy, steps_left} !== {3'b100, 16'd0}) begin
            nfail++;
            $display("FAIL abort_run rhb=%b steps=%0d exp rhb=100 steps=0", {run, halted, busy}, steps_left);
        end
    endtask

    task automatic test_reset_mid_step();
        go_halted();
        cmd_step = 1'b1;
        step_count = 16'd8;
        tick();
        cmd_step = 1'b0;
        stopped = 1'b0;
        for (int i = 0; i < 3; i++) cs_pulse(1'b0);
        ncmp++;
        if ({busy, steps_left} !== {1'b1, 16'd5}) begin
            nfail++;
            $display("FAIL pre_reset busy=%b steps=%0d exp busy=1 steps=5", busy, steps_left);
        end
        #2;
        resetn = 1'b0;
        #1;
        ncmp++;
        if ({run, halted, busy, steps_left, cycle_cnt} !== {3'b100, 16'd0, 32'd0}) begin
            nfail++;
            $display("FAIL async_reset rhb=%b steps=%0d cnt=%0d exp rhb=100 0 0",
                     {run, halted, busy}, steps_left, cycle_cnt);
        end
        tick();
        resetn = 1'b1;
        cs_pulse(1'b0);
        ncmp++;
        if ({run, halted, busy, cycle_cnt} !== {3'b100, 32'd1}) begin
            nfail++;
            $display("FAIL after_reset rhb=%b cnt=%0d exp rhb=100 cnt=1", {run, halted, busy}, cycle_cnt);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_free_run();
        test_stop();
        test_step_cycles();
        test_step_instr();
        test_priority();
        test_clr_cnt();
        test_wrap_and_held_boot();
        test_step_abort();
        test_reset_mid_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
